// File: rtl/bp_me_mem_cmd_resp_buffer_mc.sv
// Multi-channel memory command/response buffer.
// N CCE-side channels share one memory port. Each channel has a command FIFO;
// a round-robin arbiter picks one to issue. A tag FIFO routes each memory
// response back to its channel's response FIFO. Response credits are reserved
// when a command issues.
// Optional feature: define BP_ME_MEM_BUF_ISSUE_STATS_EN for per-channel
// 32-bit issue counters on issue_cnt_o; otherwise issue_cnt_o is tied to 0.
module bp_me_mem_cmd_resp_buffer_mc #(
  parameter int unsigned num_chan_p  = 2,
  parameter int unsigned msg_width_p = 128,
  parameter int unsigned cmd_els_p   = 4,
  parameter int unsigned resp_els_p  = 4,
  parameter int unsigned max_out_p   = 4,
  localparam int unsigned chan_id_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int unsigned out_width_lp     = $clog2(max_out_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_chan_p*msg_width_p-1:0] cmd_i,
  input  logic [num_chan_p-1:0]             cmd_v_i,
  output logic [num_chan_p-1:0]             cmd_ready_o,
  output logic [num_chan_p*msg_width_p-1:0] resp_o,
  output logic [num_chan_p-1:0]             resp_v_o,
  input  logic [num_chan_p-1:0]             resp_yumi_i,
  output logic [msg_width_p-1:0]            mem_cmd_o,
  output logic                              mem_cmd_v_o,
  input  logic                              mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]            mem_resp_i,
  input  logic                              mem_resp_v_i,
  output logic                              mem_resp_yumi_o,
  output logic [out_width_lp-1:0]           outstanding_o,
  output logic [num_chan_p*32-1:0]          issue_cnt_o
);

  localparam int unsigned cw_lp        = chan_id_width_lp;
  localparam int unsigned cand_w_lp    = chan_id_width_lp + 1;
  localparam int unsigned cmd_ptr_w_lp = (cmd_els_p > 1) ? $clog2(cmd_els_p) : 1;
  localparam int unsigned cmd_cnt_w_lp = $clog2(cmd_els_p + 1);
  localparam int unsigned rsp_ptr_w_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int unsigned rsp_cnt_w_lp = $clog2(resp_els_p + 1);
  localparam int unsigned tag_ptr_w_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;
  localparam int unsigned credit_w_lp  = $clog2(resp_els_p + 1);

  logic [num_chan_p-1:0]  cmd_full, cmd_empty, cmd_enq, cmd_deq, elig;
  logic [num_chan_p-1:0]  resp_full, resp_empty, resp_enq, resp_deq;
  logic [msg_width_p-1:0] cmd_head [num_chan_p];
  logic [cw_lp-1:0]       grant, rr_ptr;
  logic [cand_w_lp-1:0]   cand;
  logic                   grant_v, issue, retire;

  logic [cw_lp-1:0]        tag_mem [max_out_p];
  logic [tag_ptr_w_lp-1:0] tag_rd, tag_wr;
  logic [out_width_lp-1:0] tag_cnt;
  logic                    tag_full, tag_empty;
  logic [cw_lp-1:0]        tag_head;

  assign tag_full  = (tag_cnt == out_width_lp'(max_out_p));
  assign tag_empty = (tag_cnt == '0);
  assign tag_head  = tag_mem[tag_rd];

  assign cmd_ready_o     = {num_chan_p{reset_n_i}} & ~cmd_full;
  assign mem_cmd_v_o     = reset_n_i & grant_v;
  assign mem_cmd_o       = cmd_head[grant];
  assign issue           = mem_cmd_v_o & mem_cmd_ready_i;
  assign mem_resp_yumi_o = reset_n_i & mem_resp_v_i & ~tag_empty & ~resp_full[tag_head];
  assign retire          = mem_resp_yumi_o;
  assign outstanding_o   = tag_cnt;

  // Round-robin grant: first eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    grant   = '0;
    grant_v = 1'b0;
    cand    = '0;
    for (int i = 0; i < int'(num_chan_p); i++) begin
      cand = {1'b0, rr_ptr} + cand_w_lp'(i);
      if (cand >= cand_w_lp'(num_chan_p)) cand = cand - cand_w_lp'(num_chan_p);
      if (!grant_v && elig[cand[cw_lp-1:0]]) begin
        grant_v = 1'b1;
        grant   = cand[cw_lp-1:0];
      end
    end
  end

  // Round-robin pointer and tag FIFO control.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_ptr  <= '0;
      tag_rd  <= '0;
      tag_wr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (grant == cw_lp'(num_chan_p - 1)) ? '0 : grant + cw_lp'(1);
        tag_wr <= (tag_wr == tag_ptr_w_lp'(max_out_p - 1)) ? '0 : tag_wr + tag_ptr_w_lp'(1);
      end
      if (retire)
        tag_rd <= (tag_rd == tag_ptr_w_lp'(max_out_p - 1)) ? '0 : tag_rd + tag_ptr_w_lp'(1);
      tag_cnt <= tag_cnt + out_width_lp'(issue) - out_width_lp'(retire);
    end
  end

  // Tag storage: the channel id of each issued command, in issue order.
  always_ff @(posedge clk_i) begin
    if (issue) tag_mem[tag_wr] <= grant;
  end

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    logic [msg_width_p-1:0]  cmd_mem [cmd_els_p];
    logic [cmd_ptr_w_lp-1:0] cmd_rd, cmd_wr;
    logic [cmd_cnt_w_lp-1:0] cmd_cnt;
    logic [msg_width_p-1:0]  rsp_mem [resp_els_p];
    logic [rsp_ptr_w_lp-1:0] rsp_rd, rsp_wr;
    logic [rsp_cnt_w_lp-1:0] rsp_cnt;
    logic [credit_w_lp-1:0]  credit;

    assign cmd_full[c]   = (cmd_cnt == cmd_cnt_w_lp'(cmd_els_p));
    assign cmd_empty[c]  = (cmd_cnt == '0);
    assign cmd_enq[c]    = cmd_v_i[c] & cmd_ready_o[c];
    assign cmd_deq[c]    = issue & (grant == cw_lp'(c));
    assign cmd_head[c]   = cmd_mem[cmd_rd];
    assign elig[c]       = ~cmd_empty[c] & (credit != '0) & ~tag_full;
    assign resp_full[c]  = (rsp_cnt == rsp_cnt_w_lp'(resp_els_p));
    assign resp_empty[c] = (rsp_cnt == '0);
    assign resp_enq[c]   = retire & (tag_head == cw_lp'(c));
    assign resp_deq[c]   = resp_yumi_i[c] & resp_v_o[c];
    assign resp_v_o[c]   = reset_n_i & ~resp_empty[c];
    assign resp_o[c*msg_width_p +: msg_width_p] = rsp_mem[rsp_rd];

    // FIFO pointers, occupancy and response credit.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        cmd_rd  <= '0;
        cmd_wr  <= '0;
        cmd_cnt <= '0;
        rsp_rd  <= '0;
        rsp_wr  <= '0;
        rsp_cnt <= '0;
        credit  <= credit_w_lp'(resp_els_p);
      end else begin
        if (cmd_enq[c])
          cmd_wr <= (cmd_wr == cmd_ptr_w_lp'(cmd_els_p - 1)) ? '0 : cmd_wr + cmd_ptr_w_lp'(1);
        if (cmd_deq[c])
          cmd_rd <= (cmd_rd == cmd_ptr_w_lp'(cmd_els_p - 1)) ? '0 : cmd_rd + cmd_ptr_w_lp'(1);
        if (resp_enq[c])
          rsp_wr <= (rsp_wr == rsp_ptr_w_lp'(resp_els_p - 1)) ? '0 : rsp_wr + rsp_ptr_w_lp'(1);
        if (resp_deq[c])
          rsp_rd <= (rsp_rd == rsp_ptr_w_lp'(resp_els_p - 1)) ? '0 : rsp_rd + rsp_ptr_w_lp'(1);
        cmd_cnt <= cmd_cnt + cmd_cnt_w_lp'(cmd_enq[c]) - cmd_cnt_w_lp'(cmd_deq[c]);
        rsp_cnt <= rsp_cnt + rsp_cnt_w_lp'(resp_enq[c]) - rsp_cnt_w_lp'(resp_deq[c]);
        credit  <= credit + credit_w_lp'(resp_deq[c]) - credit_w_lp'(cmd_deq[c]);
      end
    end

    // Payload storage; no reset needed, occupancy guards reads.
    always_ff @(posedge clk_i) begin
      if (cmd_enq[c])  cmd_mem[cmd_wr] <= cmd_i[c*msg_width_p +: msg_width_p];
      if (resp_enq[c]) rsp_mem[rsp_wr] <= mem_resp_i;
    end

`ifdef BP_ME_MEM_BUF_ISSUE_STATS_EN
    logic [31:0] issue_cnt;
    // Issue counter for this channel, wraps modulo 2^32.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i)      issue_cnt <= '0;
      else if (cmd_deq[c]) issue_cnt <= issue_cnt + 32'd1;
    end
    assign issue_cnt_o[c*32 +: 32] = issue_cnt;
`else
    assign issue_cnt_o[c*32 +: 32] = '0;
`endif
  end

  // Protocol checks on the CCE and memory sides.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(|(cmd_v_i & cmd_full))) else $error("command enqueue while FIFO full");
      assert (!(|(resp_yumi_i & ~resp_v_o))) else $error("resp_yumi_i without resp_v_o");
      assert (!(mem_resp_v_i && tag_empty)) else $error("memory response with no command in flight");
    end
  end

endmodule

// File: tb/tb_bp_me_mem_cmd_resp_buffer_mc.sv
// Scoreboard bench for bp_me_mem_cmd_resp_buffer_mc (2 channels, 128-bit messages).
// The memory model answers each command with its bitwise inverse.
module tb_bp_me_mem_cmd_resp_buffer_mc;

  localparam int W = 128;

  logic           clk = 1'b0;
  logic           reset_n_i;
  logic [2*W-1:0] cmd_i;
  logic [1:0]     cmd_v_i, cmd_ready_o, resp_v_o, resp_yumi_i;
  logic [2*W-1:0] resp_o;
  logic [W-1:0]   mem_cmd_o, mem_resp_i;
  logic           mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_o;
  logic [2:0]     outstanding_o;
  logic [63:0]    issue_cnt_o;

  logic [W-1:0] exp_r0[$], exp_r1[$], exp_mem[$], pend[$];
  int           iss0, iss1;
  logic         mem_hold;
  logic [1:0]   resp_en;
  int           errors = 0;
  int           checks = 0;

  bp_me_mem_cmd_resp_buffer_mc #(
    .num_chan_p(2), .msg_width_p(W), .cmd_els_p(4), .resp_els_p(4), .max_out_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .issue_cnt_o(issue_cnt_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int t, input int c, input int s);
    return {64'hA5A5_0F0F_3C3C_9696, 32'(t), 16'(c), 16'(s)};
  endfunction

  // Memory model: one-cycle response latency, optional hold, order checker.
  initial begin
    logic rel;
    mem_resp_v_i = 1'b0;
    mem_resp_i   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) pend.delete();
      else begin
        if (mem_resp_v_i && mem_resp_yumi_o) void'(pend.pop_front());
        if (mem_cmd_v_o && mem_cmd_ready_i) begin
          pend.push_back(mem_cmd_o);
          if (mem_cmd_o[31:16] == 16'd0) iss0++; else iss1++;
          if (exp_mem.size() != 0) check("mem cmd order", mem_cmd_o, exp_mem.pop_front());
        end
      end
      rel = !mem_hold && (pend.size() != 0);
      @(posedge clk); #1;
      mem_resp_v_i = rel;
      mem_resp_i   = rel ? ~pend[0] : '0;
    end
  end

  // Response monitor: consume enabled channels and compare with the scoreboard.
  initial begin
    resp_yumi_i = '0;
    forever begin
      @(negedge clk);
      resp_yumi_i = resp_v_o & resp_en;
      if (resp_yumi_i[0]) begin
        if (exp_r0.size() == 0) check("resp ch0 unexpected", resp_o[W-1:0], '0);
        else check("resp ch0", resp_o[W-1:0], exp_r0.pop_front());
      end
      if (resp_yumi_i[1]) begin
        if (exp_r1.size() == 0) check("resp ch1 unexpected", resp_o[2*W-1:W], '0);
        else check("resp ch1", resp_o[2*W-1:W], exp_r1.pop_front());
      end
    end
  end

  // Called at posedge+1; presents one cycle of commands, returns at next posedge+1.
  task automatic drive(input logic [1:0] v, input logic [W-1:0] p0, input logic [W-1:0] p1);
    check("cmd_ready before enqueue", W'(cmd_ready_o & v), W'(v));
    cmd_i   = {p1, p0};
    cmd_v_i = v & cmd_ready_o;
    if (v[0]) exp_r0.push_back(~p0);
    if (v[1]) exp_r1.push_back(~p1);
    @(posedge clk); #1;
    cmd_v_i = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n_i = 1'b0;
    @(negedge clk);
    check("rst cmd_ready", W'(cmd_ready_o), '0);
    check("rst resp_v", W'(resp_v_o), '0);
    check("rst mem_cmd_v", W'(mem_cmd_v_o), '0);
    check("rst mem_resp_yumi", W'(mem_resp_yumi_o), '0);
    @(posedge clk); #1;
    exp_r0.delete(); exp_r1.delete(); exp_mem.delete();
    iss0 = 0; iss1 = 0;
    @(negedge clk);
    check("rst outstanding", W'(outstanding_o), '0);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(negedge clk);
    check("post-rst cmd_ready", W'(cmd_ready_o), W'(2'b11));
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int  n    = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_r0.size() == 0) && (exp_r1.size() == 0) && (outstanding_o == 3'd0) && !mem_cmd_v_o;
    end
    check(name, W'(done), W'(1'b1));
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n_i = 1'b0; cmd_i = '0; cmd_v_i = '0;
    mem_cmd_ready_i = 1'b1; mem_hold = 1'b0; resp_en = 2'b11;
    iss0 = 0; iss1 = 0;
    repeat (2) @(posedge clk);

    // 1: single read latency
    do_reset();
    cmd_i[W-1:0] = mk(1, 0, 0); cmd_v_i = 2'b01;
    exp_r0.push_back(~mk(1, 0, 0)); exp_mem.push_back(mk(1, 0, 0));
    @(negedge clk); check("t1 mem_cmd_v enq cycle", W'(mem_cmd_v_o), '0);
    @(posedge clk); #1; cmd_v_i = '0;
    @(negedge clk); check("t1 mem_cmd_v t+1", W'(mem_cmd_v_o), W'(1'b1));
    check("t1 outstanding t+1", W'(outstanding_o), '0);
    @(negedge clk); check("t1 resp_v t+2", W'(resp_v_o[0]), '0);
    check("t1 outstanding t+2", W'(outstanding_o), W'(3'd1));
    @(negedge clk); check("t1 resp_v t+3", W'(resp_v_o[0]), W'(1'b1));
    check("t1 outstanding t+3", W'(outstanding_o), '0);
    @(posedge clk); #1;
    wait_idle("t1 idle", 20);

    // 2: round-robin order with both channels loaded
    do_reset();
    mem_cmd_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      exp_mem.push_back(mk(2, 0, s));
      exp_mem.push_back(mk(2, 1, s));
    end
    for (int s = 0; s < 3; s++) drive(2'b11, mk(2, 0, s), mk(2, 1, s));
    mem_cmd_ready_i = 1'b1;
    wait_idle("t2 idle", 40);
    check("t2 order consumed", W'(exp_mem.size()), '0);

    // 3: blocked channel 1 consumer does not stall channel 0
    do_reset();
    resp_en = 2'b01;
    for (int s = 0; s < 6; s++) drive(2'b10, '0, mk(3, 1, s));
    repeat (10) @(negedge clk);
    check("t3 ch1 issues at credit limit", W'(iss1), W'(4));
    check("t3 ch1 resp held", W'(resp_v_o[1]), W'(1'b1));
    check("t3 mem_cmd_v idle", W'(mem_cmd_v_o), '0);
    check("t3 outstanding", W'(outstanding_o), '0);
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) drive(2'b01, mk(3, 0, s), '0);
    begin
      int n = 0;
      while (exp_r0.size() != 0 && n < 40) begin @(negedge clk); n++; end
    end
    check("t3 ch0 drained", W'(exp_r0.size()), '0);
    check("t3 ch1 still blocked", W'(iss1), W'(4));
    @(posedge clk); #1;
    resp_en = 2'b11;
    wait_idle("t3 idle", 60);
    check("t3 ch1 total issues", W'(iss1), W'(6));

    // 4: outstanding limit
    do_reset();
    mem_hold = 1'b1;
    drive(2'b11, mk(4, 0, 0), mk(4, 1, 0));
    drive(2'b11, mk(4, 0, 1), mk(4, 1, 1));
    drive(2'b01, mk(4, 0, 2), '0);
    repeat (8) @(negedge clk);
    check("t4 issued at limit", W'(iss0 + iss1), W'(4));
    check("t4 mem_cmd_v blocked", W'(mem_cmd_v_o), '0);
    check("t4 outstanding full", W'(outstanding_o), W'(3'd4));
    @(posedge clk); #1;
    mem_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4 resp yumi", W'(mem_resp_yumi_o), W'(1'b1));
    check("t4 still blocked", W'(mem_cmd_v_o), '0);
    @(negedge clk);
    check("t4 fifth issue", W'(mem_cmd_v_o), W'(1'b1));
    check("t4 outstanding after retire", W'(outstanding_o), W'(3'd3));
    @(posedge clk); #1;
    wait_idle("t4 idle", 40);
    check("t4 total issued", W'(iss0 + iss1), W'(5));

    // 5: reset with commands in flight and queued
    do_reset();
    mem_hold = 1'b1;
    drive(2'b11, mk(5, 0, 0), mk(5, 1, 0));
    drive(2'b01, mk(5, 0, 1), '0);
    repeat (4) @(negedge clk);
    check("t5 in flight", W'(outstanding_o), W'(3'd3));
    @(posedge clk); #1;
    mem_cmd_ready_i = 1'b0;
    drive(2'b11, mk(5, 0, 2), mk(5, 1, 1));
    @(negedge clk);
    check("t5 queued valid", W'(mem_cmd_v_o), W'(1'b1));
    do_reset();
    mem_hold = 1'b0;
    mem_cmd_ready_i = 1'b1;
    exp_mem.push_back(mk(5, 1, 9));
    drive(2'b10, '0, mk(5, 1, 9));
    wait_idle("t5 idle", 30);
    check("t5 first new issue", W'(exp_mem.size()), '0);

    // 6: issue statistics
    do_reset();
    for (int s = 0; s < 5; s++) drive({(s < 2), 1'b1}, mk(6, 0, s), mk(6, 1, s));
    wait_idle("t6 idle", 40);
`ifdef BP_ME_MEM_BUF_ISSUE_STATS_EN
    check("t6 issue_cnt", W'(issue_cnt_o), W'({32'd2, 32'd5}));
`else
    check("t6 issue_cnt", W'(issue_cnt_o), '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
